// File: rtl/random_seq_pkg.sv
// Shared constants for the 3-bit pseudo-random sequence stream.
// The generator and the checker both import this package, so both ends use the same sequence.
package random_seq_pkg;

  localparam int SEQ_LEN = 8;

  // SEQ[0] is the rightmost element: 0,3,5,1,7,2,6,4
  localparam logic [SEQ_LEN-1:0][2:0] SEQ = {3'd4, 3'd6, 3'd2, 3'd7, 3'd1, 3'd5, 3'd3, 3'd0};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // The sequence is a permutation, so every value has exactly one position.
  function automatic logic [2:0] pos(input logic [2:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < SEQ_LEN; i++)
      if (SEQ[i] == v) p = 3'(i);
    return p;
  endfunction

endpackage

// File: rtl/seq_pos_lut.sv
// Combinational inverse of the sequence table: maps a received value to its sequence index.
module seq_pos_lut
  import random_seq_pkg::*;
(
  input  logic [2:0] i_val,
  output logic [2:0] o_pos
);

  assign o_pos = pos(i_val);

endmodule

// File: rtl/random_seq_checker.sv
// Receive-side checker: acquires lock on the 8-entry sequence, tracks it with a
// flywheel index, pulses match/err/wrap, and keeps a saturating error count.
module random_seq_checker
  import random_seq_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_din_valid,
  input  logic [2:0]       i_din,
  output logic             o_locked,
  output logic             o_match,
  output logic             o_err,
  output logic             o_wrap,
  output logic [2:0]       o_expected,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);

  state_t           r_state, w_state_nx;
  logic [2:0]       r_idx, w_idx_nx, w_idx_inc, w_idx_nx_inc, w_exp_cur, w_din_pos;
  logic [GW-1:0]    r_good, w_good_nx;
  logic [MW-1:0]    r_miss, w_miss_nx;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nx;
  logic             w_match, w_err, w_wrap;
  logic [2:0]       w_exp_nx;
  logic             r_locked, r_match, r_err, r_wrap;
  logic [2:0]       r_expected;

  seq_pos_lut u_pos (
    .i_val (i_din),
    .o_pos (w_din_pos)
  );

  assign w_idx_inc = r_idx + 3'd1;
  assign w_exp_cur = SEQ[w_idx_inc];

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_good_nx    = r_good;
    w_miss_nx    = r_miss;
    w_err_cnt_nx = r_err_cnt;
    w_match      = 1'b0;
    w_err        = 1'b0;
    w_wrap       = 1'b0;
    if (i_din_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          w_idx_nx   = w_din_pos;
          w_good_nx  = GW'(1);
          w_miss_nx  = '0;
          w_state_nx = (LOCK_N == 1) ? ST_LOCKED : ST_CHECK;
        end
        ST_CHECK: begin
          if (i_din == w_exp_cur) begin
            w_idx_nx  = w_idx_inc;
            w_good_nx = r_good + GW'(1);
            if (w_good_nx == GW'(LOCK_N)) begin
              w_state_nx = ST_LOCKED;
              w_miss_nx  = '0;
            end
          end else begin
            w_idx_nx  = w_din_pos;
            w_good_nx = GW'(1);
          end
        end
        ST_LOCKED: begin
          // Flywheel: advance on both hit and miss so one corrupt word costs one error.
          w_idx_nx = w_idx_inc;
          if (i_din == w_exp_cur) begin
            w_match   = 1'b1;
            w_wrap    = (w_idx_inc == 3'd0);
            w_miss_nx = '0;
          end else begin
            w_err        = 1'b1;
            w_err_cnt_nx = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_W'(1);
            w_miss_nx    = r_miss + MW'(1);
            if (w_miss_nx == MW'(LOSS_N)) begin
              w_state_nx = ST_HUNT;
              w_idx_nx   = 3'd0;
              w_good_nx  = '0;
              w_miss_nx  = '0;
            end
          end
        end
        default: w_state_nx = ST_HUNT;
      endcase
    end
    w_idx_nx_inc = w_idx_nx + 3'd1;
    w_exp_nx     = (w_state_nx == ST_HUNT) ? 3'd0 : SEQ[w_idx_nx_inc];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_HUNT;
      r_idx      <= 3'd0;
      r_good     <= '0;
      r_miss     <= '0;
      r_err_cnt  <= '0;
      r_locked   <= 1'b0;
      r_match    <= 1'b0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_expected <= 3'd0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_good     <= w_good_nx;
      r_miss     <= w_miss_nx;
      r_err_cnt  <= w_err_cnt_nx;
      r_locked   <= (w_state_nx == ST_LOCKED);
      r_match    <= w_match;
      r_err      <= w_err;
      r_wrap     <= w_wrap;
      r_expected <= w_exp_nx;
    end
  end

  assign o_locked    = r_locked;
  assign o_match     = r_match;
  assign o_err       = r_err;
  assign o_wrap      = r_wrap;
  assign o_expected  = r_expected;
  assign o_err_count = r_err_cnt;

endmodule

// File: tb/tb_random_seq_checker.sv
// Bench for random_seq_checker: directed scenarios plus a random stream, checked
// against a sequence-level reference model (two instances: default and LOSS_N=300).
module tb_random_seq_checker;

  logic       clk = 1'b0;
  logic       rst, vld;
  logic [2:0] din;

  logic       a_locked, a_match, a_err, a_wrap;
  logic [2:0] a_expected;
  logic [7:0] a_err_count;
  logic       b_locked, b_match, b_err, b_wrap;
  logic [2:0] b_expected;
  logic [7:0] b_err_count;

  int errors = 0;
  int checks = 0;

  random_seq_checker u_a (
    .i_clk(clk), .i_rst(rst), .i_din_valid(vld), .i_din(din),
    .o_locked(a_locked), .o_match(a_match), .o_err(a_err), .o_wrap(a_wrap),
    .o_expected(a_expected), .o_err_count(a_err_count)
  );

  random_seq_checker #(.LOCK_N(3), .LOSS_N(300), .CNT_W(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_din_valid(vld), .i_din(din),
    .o_locked(b_locked), .o_match(b_match), .o_err(b_err), .o_wrap(b_wrap),
    .o_expected(b_expected), .o_err_count(b_err_count)
  );

  always #5 clk = ~clk;

  // Reference model: position in the sequence, run-lengths of good/bad words.
  int  seq[8]  = '{0, 3, 5, 1, 7, 2, 6, 4};
  int  loss[2] = '{2, 300};
  bit  m_hunting[2], m_locked[2], m_match[2], m_err[2], m_wrap[2];
  int  m_idx[2], m_good[2], m_miss[2], m_cnt[2];

  function automatic int pos_of(int v);
    for (int i = 0; i < 8; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  function automatic int m_exp(int k);
    return m_hunting[k] ? 0 : seq[(m_idx[k] + 1) % 8];
  endfunction

  function automatic logic [14:0] m_vec(int k);
    return {m_locked[k], m_match[k], m_err[k], m_wrap[k], 3'(m_exp(k)), 8'(m_cnt[k])};
  endfunction

  task automatic model_step(int k, bit r, bit v, int d);
    int want;
    m_match[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
    if (r) begin
      m_hunting[k] = 1; m_locked[k] = 0;
      m_idx[k] = 0; m_good[k] = 0; m_miss[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (!v) return;
    want = seq[(m_idx[k] + 1) % 8];
    if (m_hunting[k]) begin
      m_hunting[k] = 0; m_idx[k] = pos_of(d); m_good[k] = 1;
    end else if (!m_locked[k]) begin
      if (d == want) begin
        m_idx[k] = (m_idx[k] + 1) % 8; m_good[k]++;
        if (m_good[k] == 3) begin m_locked[k] = 1; m_miss[k] = 0; end
      end else begin
        m_idx[k] = pos_of(d); m_good[k] = 1;
      end
    end else begin
      m_idx[k] = (m_idx[k] + 1) % 8;
      if (d == want) begin
        m_match[k] = 1; m_miss[k] = 0; m_wrap[k] = (m_idx[k] == 0);
      end else begin
        m_err[k] = 1; m_miss[k]++;
        if (m_cnt[k] < 255) m_cnt[k]++;
        if (m_miss[k] == loss[k]) begin
          m_locked[k] = 0; m_hunting[k] = 1;
          m_idx[k] = 0; m_good[k] = 0; m_miss[k] = 0;
        end
      end
    end
  endtask

  task automatic cyc(bit r, bit v, int d);
    rst = r; vld = v; din = 3'(d);
    @(posedge clk);
    model_step(0, r, v, d);
    model_step(1, r, v, d);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 5);
    cyc(1, 0, 0);
    checks++;
    if ({a_locked, a_match, a_err, a_wrap} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0000", {a_locked, a_match, a_err, a_wrap});
    end
    checks++;
    if (a_expected !== 3'd0) begin errors++; $display("FAIL reset_expected got=%0d want=0", a_expected); end
    checks++;
    if (a_err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d want=0", a_err_count); end
  endtask

  task automatic test_acquire();
    int v[3] = '{0, 3, 5};
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, v[i]);
      checks++;
      if (a_match !== 1'b0) begin errors++; $display("FAIL acq_match[%0d] got=%b want=0", i, a_match); end
      checks++;
      if (a_locked !== (i == 2)) begin errors++; $display("FAIL acq_locked[%0d] got=%b want=%0d", i, a_locked, i == 2); end
    end
    checks++;
    if (a_expected !== 3'd1) begin errors++; $display("FAIL acq_expected got=%0d want=1", a_expected); end
    checks++;
    if (a_err_count !== 8'd0) begin errors++; $display("FAIL acq_err_count got=%0d want=0", a_err_count); end
  endtask

  task automatic test_wrap();
    int v[6] = '{1, 7, 2, 6, 4, 0};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, v[i]);
      checks++;
      if ({a_match, a_err, a_wrap} !== {1'b1, 1'b0, i == 5}) begin
        errors++; $display("FAIL wrap_pulses[%0d] got=%b want=10%0d", i, {a_match, a_err, a_wrap}, i == 5);
      end
    end
    checks++;
    if (a_expected !== 3'd3) begin errors++; $display("FAIL wrap_expected got=%0d want=3", a_expected); end
  endtask

  task automatic test_flywheel();
    int v[4] = '{3, 5, 1, 7};
    for (int i = 0; i < 4; i++) cyc(0, 1, v[i]);
    checks++;
    if (a_expected !== 3'd2) begin errors++; $display("FAIL fly_pre_expected got=%0d want=2", a_expected); end
    cyc(0, 1, 6);
    checks++;
    if ({a_err, a_match, a_err_count, a_expected} !== {1'b1, 1'b0, 8'd1, 3'd6}) begin
      errors++; $display("FAIL fly_miss got=%b/%b/%0d/%0d want=1/0/1/6", a_err, a_match, a_err_count, a_expected);
    end
    cyc(0, 1, 6);
    checks++;
    if ({a_match, a_err, a_locked} !== 3'b101) begin
      errors++; $display("FAIL fly_recover got=%b want=101", {a_match, a_err, a_locked});
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, m_exp(0) ^ 1);
      checks++;
      if ({a_err, a_locked} !== {1'b1, i == 0}) begin
        errors++; $display("FAIL loss_step[%0d] got=%b want=1%0d", i, {a_err, a_locked}, i == 0);
      end
    end
    checks++;
    if ({a_err_count, a_expected} !== {8'd3, 3'd0}) begin
      errors++; $display("FAIL loss_final got=%0d/%0d want=3/0", a_err_count, a_expected);
    end
  endtask

  task automatic test_gap();
    cyc(0, 1, 0);
    cyc(0, 1, 3);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, $urandom_range(0, 7));
      checks++;
      if ({a_locked, a_match, a_err, a_expected} !== {3'b000, 3'd5}) begin
        errors++; $display("FAIL gap_hold[%0d] got=%b/%0d want=000/5", i, {a_locked, a_match, a_err}, a_expected);
      end
    end
    cyc(0, 1, 5);
    checks++;
    if (a_locked !== 1'b1) begin errors++; $display("FAIL gap_lock got=%b want=1", a_locked); end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2 == 0) ? (m_exp(0) ^ 1) : m_exp(0));
    checks++;
    if ({a_locked, a_err_count} !== {1'b1, 8'd5}) begin
      errors++; $display("FAIL mid_pre got=%b/%0d want=1/5", a_locked, a_err_count);
    end
    cyc(1, 1, m_exp(0));
    checks++;
    if ({a_locked, a_match, a_err, a_wrap, a_expected, a_err_count} !== 15'd0) begin
      errors++; $display("FAIL mid_reset got=%h want=0", {a_locked, a_match, a_err, a_wrap, a_expected, a_err_count});
    end
  endtask

  task automatic test_saturation();
    cyc(0, 1, 0); cyc(0, 1, 3); cyc(0, 1, 5);
    for (int i = 0; i < 260; i++) begin
      cyc(0, 1, m_exp(1) ^ 1);
      if (i == 254) begin
        checks++;
        if (b_err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d want=255", b_err_count); end
      end
    end
    checks++;
    if ({b_locked, b_err, b_err_count} !== {2'b11, 8'd255}) begin
      errors++; $display("FAIL sat_hold got=%b/%b/%0d want=1/1/255", b_locked, b_err, b_err_count);
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit v;
      int d;
      v = ($urandom_range(0, 9) < 8);
      d = ($urandom_range(0, 9) < 7) ? m_exp(0) : int'($urandom_range(0, 7));
      cyc(0, v, d);
      checks++;
      if ({a_locked, a_match, a_err, a_wrap, a_expected, a_err_count} !== m_vec(0)) begin
        errors++; $display("FAIL rand_a[%0d] got=%h want=%h", i,
          {a_locked, a_match, a_err, a_wrap, a_expected, a_err_count}, m_vec(0));
      end
      checks++;
      if ({b_locked, b_match, b_err, b_wrap, b_expected, b_err_count} !== m_vec(1)) begin
        errors++; $display("FAIL rand_b[%0d] got=%h want=%h", i,
          {b_locked, b_match, b_err, b_wrap, b_expected, b_err_count}, m_vec(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; din = 3'd0;
    test_reset();
    test_acquire();
    test_wrap();
    test_flywheel();
    test_loss();
    test_gap();
    test_midreset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/random_seq_checker.md
Name: random_seq_checker

Overview:
- Receive-side checker for the 3-bit pseudo-random sequence produced by the sequence generator block (qout stream).
- Samples a 3-bit input word when qualified by valid, acquires lock on the fixed 8-entry sequence, and then tracks it while flagging mismatches.
- Counts errors, drops lock after repeated misses, and re-hunts.
- Sits at the consumer end of the generator's output, e.g. as a self-check monitor in loopback.

Parameters:
- LOCK_N, 3: consecutive in-order samples, counting the first, required to declare lock.
- LOSS_N, 2: consecutive mismatches while locked that force loss of lock.
- CNT_W, 8: err_count width; the counter saturates.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din_valid  input  1  din is sampled on a clk edge only when this is 1
- din  input  3  received sequence word
- locked  output  1  level; 1 while in LOCKED state
- match  output  1  one-cycle pulse; accepted sample equalled expected while LOCKED
- err  output  1  one-cycle pulse; accepted sample mismatched while LOCKED
- wrap  output  1  one-cycle pulse; matched SEQ[0] immediately after SEQ[7] while LOCKED
- expected  output  3  SEQ[(idx+1) mod 8]; valid in CHECK and LOCKED, 0 in HUNT
- err_count  output  CNT_W  saturating count of err pulses since reset

Behaviour:
- Sequence SEQ[0..7] = 0,3,5,1,7,2,6,4. It is a permutation, so every 3-bit value has a unique position pos(v).
- Reset (synchronous, rst=1 at a clk edge): state=HUNT, idx=0, good_cnt=0, miss_cnt=0. All outputs 0, err_count=0.
  - Reset overrides any in-flight sample.
  - A mid-operation reset clears lock and counts on that edge.
- All outputs are registered. Response appears the cycle after the edge that accepted the sample.
- din_valid=0: state, idx and counters hold; match/err/wrap=0.
- HUNT, on valid:
  - idx<=pos(din), good_cnt<=1, go to CHECK.
  - If LOCK_N==1, go directly to LOCKED instead.
- CHECK, on valid:
  - If din==SEQ[(idx+1) mod 8]: idx<=idx+1 mod 8, good_cnt<=good_cnt+1. When good_cnt+1==LOCK_N, go to LOCKED with miss_cnt<=0.
  - Else resync: idx<=pos(din), good_cnt<=1, stay in CHECK.
  - No match/err pulses and no err_count change in CHECK.
- LOCKED, on valid:
  - Match: match=1, idx advances, miss_cnt<=0. If the new idx==0, wrap=1.
  - Mismatch: err=1, err_count<=min(err_count+1, 2^CNT_W-1), miss_cnt<=miss_cnt+1.
    - idx still advances (flywheel: the next expected value is the successor of the value that was expected, not resynced to din).
    - When miss_cnt+1==LOSS_N: go to HUNT, locked<=0, idx<=0, good_cnt<=0, miss_cnt<=0.
- err_count is never cleared except by rst, and it holds at all-ones once saturated.
- match, err and wrap are mutually exclusive with each other except for the match+wrap pair.

Decomposition:
- Shared package random_seq_pkg holds:
  - SEQ_LEN=8 and the SEQ constant array.
  - State encoding typedef (HUNT/CHECK/LOCKED).
  - pos() lookup function.
- The generator side should use the same package constant so both ends of the stream agree.
- One natural sub-module: seq_pos_lut (3-bit value -> 3-bit index, combinational). Everything else stays in one FSM + datapath module.

Test Plan:
- Reset, then valid each cycle with din=0,3,5 -> locked=1 the cycle after the 5 is accepted; expected=1; match=0 throughout acquisition; err_count=0.
- Locked, then feed 1,7,2,6,4,0 -> six match pulses, wrap=1 only on the cycle after 0 is accepted, expected=3 afterwards.
- Locked, expected=2; feed 6 -> err=1, err_count=1, expected=6 (flywheel). Then feed 6 -> match=1, locked stays 1.
- Locked; feed two consecutive wrong values (e.g. 0,0 when 2 then 6 are expected) -> err pulses on both, err_count=2, locked=0 after the second, expected=0.
- Ready to lock (two good samples, e.g. 0,3); drive din_valid=0 for 5 cycles with garbage din, then resume with the correct next value 5 -> no state change during the gap; locked=1 after the resumed sample.
  - Separate run: rst asserted mid-LOCKED with err_count=5 -> all outputs 0 on the next cycle.
- Override LOSS_N=300: lock, then feed 260 mismatches -> err_count saturates at 255, locked stays 1.
